// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder (8b/10b video, 2b control, optional TERC4 under TMDS_TERC4_EN).
// Latency: 2 ce-qualified pix_clk cycles from data/de to tmds/out_de.
// Backpressure: none; ce low freezes every register, inputs are ignored.
module tmds_encoder_multi #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 5
) (
  input  logic                   pix_clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   de,
  input  logic [2*CHANNELS-1:0]  ctrl,
  input  logic [8*CHANNELS-1:0]  data,
  input  logic                   terc4,
  input  logic [4*CHANNELS-1:0]  terc4_data,
  output logic [10*CHANNELS-1:0] tmds,
  output logic                   out_de
);

  typedef struct packed {
    logic [8:0] qm;
    logic [3:0] n1;
    logic [1:0] ctrl;
  } s1_t;

  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] ZERO = '0;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_sym = 10'h354;
      2'b01:   ctrl_sym = 10'h0AB;
      2'b10:   ctrl_sym = 10'h154;
      default: ctrl_sym = 10'h2AB;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    case (n)
      4'h0:    terc4_sym = 10'h29C;
      4'h1:    terc4_sym = 10'h263;
      4'h2:    terc4_sym = 10'h2E4;
      4'h3:    terc4_sym = 10'h2E2;
      4'h4:    terc4_sym = 10'h171;
      4'h5:    terc4_sym = 10'h11E;
      4'h6:    terc4_sym = 10'h18E;
      4'h7:    terc4_sym = 10'h13C;
      4'h8:    terc4_sym = 10'h2CC;
      4'h9:    terc4_sym = 10'h139;
      4'hA:    terc4_sym = 10'h19C;
      4'hB:    terc4_sym = 10'h2C6;
      4'hC:    terc4_sym = 10'h28E;
      4'hD:    terc4_sym = 10'h271;
      4'hE:    terc4_sym = 10'h163;
      default: terc4_sym = 10'h2C3;
    endcase
  endfunction

  logic s1_terc4;
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n)  s1_terc4 <= 1'b0;
    else if (ce) s1_terc4 <= terc4;
  end
`else
  logic unused_terc4;
  assign unused_terc4 = ^{terc4, terc4_data};
`endif

  // s1_vld keeps tmds at zero until the pipeline has refilled after reset
  logic s1_vld;
  logic s1_de;
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_de  <= 1'b0;
      out_de <= 1'b0;
    end else if (ce) begin
      s1_vld <= 1'b1;
      s1_de  <= de;
      out_de <= s1_de;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [7:0]              d;
    logic [3:0]              n1_d;
    logic                    use_xnor;
    s1_t                     s1_d;
    s1_t                     s1_q;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] diff;
    logic [9:0]              sym_d;
    logic [9:0]              sym_q;
`ifdef TMDS_TERC4_EN
    logic [3:0]              nib_q;
`endif

    assign d = data[8*k +: 8];

    always_comb begin
      s1_d     = '0;
      n1_d     = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, d[i]};
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      s1_d.qm[0] = d[0];
      for (int i = 1; i < 8; i++) s1_d.qm[i] = s1_d.qm[i-1] ^ d[i] ^ use_xnor;
      s1_d.qm[8] = !use_xnor;
      for (int i = 0; i < 8; i++) s1_d.n1 = s1_d.n1 + {3'b000, s1_d.qm[i]};
      s1_d.ctrl  = ctrl[2*k +: 2];
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= '0;
`ifdef TMDS_TERC4_EN
        nib_q <= '0;
`endif
      end else if (ce) begin
        s1_q  <= s1_d;
`ifdef TMDS_TERC4_EN
        nib_q <= terc4_data[4*k +: 4];
`endif
      end
    end

    // diff = N1 - N0 = 2*N1 - 8
    always_comb begin
      diff  = CNT_W'({s1_q.n1, 1'b0}) - CNT_W'(8);
      sym_d = '0;
      cnt_d = '0;
      if (!s1_vld) begin
        sym_d = '0;
      end else if (!s1_de) begin
`ifdef TMDS_TERC4_EN
        sym_d = s1_terc4 ? terc4_sym(nib_q) : ctrl_sym(s1_q.ctrl);
`else
        sym_d = ctrl_sym(s1_q.ctrl);
`endif
      end else if ((cnt == ZERO) || (s1_q.n1 == 4'd4)) begin
        sym_d = {~s1_q.qm[8], s1_q.qm[8], s1_q.qm[8] ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
        cnt_d = s1_q.qm[8] ? cnt + diff : cnt - diff;
      end else if ((!cnt[CNT_W-1] && (s1_q.n1 > 4'd4)) || (cnt[CNT_W-1] && (s1_q.n1 < 4'd4))) begin
        sym_d = {1'b1, s1_q.qm[8], ~s1_q.qm[7:0]};
        cnt_d = cnt - diff + (s1_q.qm[8] ? TWO : ZERO);
      end else begin
        sym_d = {1'b0, s1_q.qm[8], s1_q.qm[7:0]};
        cnt_d = cnt + diff - (s1_q.qm[8] ? ZERO : TWO);
      end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        sym_q <= '0;
      end else if (ce) begin
        cnt   <= cnt_d;
        sym_q <= sym_d;
      end
    end

    assign tmds[10*k +: 10] = sym_q;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Randomised and directed bench for tmds_encoder_multi against a delay-line plus integer-disparity reference.
module tb_tmds_encoder_multi;
  localparam int CH = 3;

  logic            pix_clk = 1'b0;
  logic            rst_n;
  logic            ce;
  logic            de;
  logic [2*CH-1:0] ctrl;
  logic [8*CH-1:0] data;
  logic            terc4;
  logic [4*CH-1:0] terc4_data;
  logic [10*CH-1:0] tmds;
  logic            out_de;

  always #5 pix_clk = ~pix_clk;

  tmds_encoder_multi #(.CHANNELS(CH), .CNT_W(5)) dut (
    .pix_clk    (pix_clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .de         (de),
    .ctrl       (ctrl),
    .data       (data),
    .terc4      (terc4),
    .terc4_data (terc4_data),
    .tmds       (tmds),
    .out_de     (out_de)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct packed {
    bit          de;
    bit          t4;
    bit [2*CH-1:0] c;
    bit [8*CH-1:0] d;
    bit [4*CH-1:0] n;
  } snap_t;

  bit [9:0] ctrl_tab [4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  bit [9:0] terc4_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                               10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
  bit [9:0] blank_exp [5]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h100};

  snap_t            m_s1;
  bit               m_vld;
  logic [10*CH-1:0] m_tmds;
  logic             m_de;
  int               m_cnt [CH];

  task automatic model_clear();
    m_vld  = 1'b0;
    m_tmds = '0;
    m_de   = 1'b0;
    for (int k = 0; k < CH; k++) m_cnt[k] = 0;
  endtask

  task automatic encode(input int k, input snap_t s, output logic [9:0] sym);
    int n1, ones, zeros, q8;
    bit xn;
    bit [7:0] dd, qm;
    dd = s.d[8*k +: 8];
    if (!s.de) begin
      m_cnt[k] = 0;
`ifdef TMDS_TERC4_EN
      if (s.t4) begin
        sym = terc4_tab[s.n[4*k +: 4]];
        return;
      end
`endif
      sym = ctrl_tab[s.c[2*k +: 2]];
      return;
    end
    n1 = $countones(dd);
    xn = (n1 > 4) || (n1 == 4 && !dd[0]);
    qm[0] = dd[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
    q8    = xn ? 0 : 1;
    ones  = $countones(qm);
    zeros = 8 - ones;
    if (m_cnt[k] == 0 || ones == 4) begin
      sym = {q8 == 0, q8 == 1, (q8 == 1) ? qm : ~qm};
      m_cnt[k] += (q8 == 1) ? (ones - zeros) : (zeros - ones);
    end else if ((m_cnt[k] > 0 && ones > 4) || (m_cnt[k] < 0 && ones < 4)) begin
      sym = {1'b1, q8 == 1, ~qm};
      m_cnt[k] += 2 * q8 + zeros - ones;
    end else begin
      sym = {1'b0, q8 == 1, qm};
      m_cnt[k] += ones - zeros - 2 * (1 - q8);
    end
  endtask

  task automatic model_edge();
    snap_t cur;
    logic [9:0] sym;
    cur = '{de: de, t4: terc4, c: ctrl, d: data, n: terc4_data};
    if (m_vld) begin
      for (int k = 0; k < CH; k++) begin
        encode(k, m_s1, sym);
        m_tmds[10*k +: 10] = sym;
      end
      m_de = m_s1.de;
    end
    m_s1  = cur;
    m_vld = 1'b1;
  endtask

  task automatic tick();
    @(posedge pix_clk);
    if (ce && rst_n) model_edge();
    #1;
    check("tmds", tmds, m_tmds);
    check("out_de", out_de, m_de);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; de = 1'b0; terc4 = 1'b0;
    ctrl = '0; data = '0; terc4_data = '0;
    model_clear();
    repeat (2) @(posedge pix_clk);
    #1;
    check("rst_tmds", tmds, 0);
    check("rst_out_de", out_de, 0);
    rst_n = 1'b1;

    // lanes 0x00 / 0xFF / 0x00 from zero disparity
    ce = 1'b1; de = 1'b1; data = {8'h00, 8'hFF, 8'h00};
    tick(); check("fill", tmds, 0);
    tick(); check("sym0", tmds, {10'h100, 10'h200, 10'h100});
    tick(); check("sym1_l0", tmds[9:0], 10'h3FF);
    tick(); check("sym2_l0", tmds[9:0], 10'h100);

    // control symbols, then video restarts from zero disparity
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        de = 1'b0; ctrl = {CH{2'(i)}};
      end else begin
        de = 1'b1; data = '0;
      end
      tick();
      if (i >= 1) check("blank", tmds, {CH{blank_exp[i-1]}});
    end

    // ce held low for 4 cycles mid-stream while inputs keep changing
    for (int i = 0; i < 16; i++) begin
      ce = !(i >= 6 && i < 10);
      de = 1'b1;
      data = 24'($urandom);
      tick();
    end
    ce = 1'b1;

    // reset during active video with non-zero disparity
    de = 1'b0; tick(); tick();
    de = 1'b1; data = '0; tick(); tick(); tick();
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_tmds", tmds, 0);
    check("mid_rst_out_de", out_de, 0);
    tick();
    rst_n = 1'b1;
    data = {8'h00, 8'hFF, 8'h00};
    tick(); check("post_rst_fill", tmds, 0);
    tick(); check("post_rst_sym", tmds, {10'h100, 10'h200, 10'h100});

    // TERC4 select during blanking
    de = 1'b0; terc4 = 1'b1; terc4_data = {4'hF, 4'h5, 4'h0}; ctrl = {2'b00, 2'b01, 2'b11};
    tick(); tick();
`ifdef TMDS_TERC4_EN
    check("terc4", tmds, {10'h2C3, 10'h11E, 10'h29C});
`else
    check("terc4_off", tmds, {10'h354, 10'h0AB, 10'h2AB});
`endif
    de = 1'b1; data = '0;
    tick(); tick();
    check("de_over_terc4", tmds, {CH{10'h100}});
    terc4 = 1'b0;

    for (int i = 0; i < 500; i++) begin
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) de = ~de;
      terc4      = 1'($urandom_range(0, 1));
      ctrl       = 6'($urandom);
      data       = ($urandom_range(0, 5) == 0) ? {CH{8'($urandom_range(0, 1) * 255)}} : 24'($urandom);
      terc4_data = 12'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
